rc_mux_seq: RTL and testbench

- Parametrised, sequential successor to the fixed 8-entry / 4-spare repair-address mux.
- Scans the must-repair flag vector of the PCAM and picks the first NSPARE flagged entries in priority order.
- Writes their addresses into the spare repair registers, with a valid flag for each one.
- Counts the total number of flagged entries, flags an unrepairable case, and uses a start/done handshake.
- Sits between PCAM fault collection and the redundancy-analysis result registers.

---
 rtl/rc_mux_seq_if.sv | 25 ++
 rtl/rc_mux_seq.sv | 86 ++++++++
 tb/tb_rc_mux_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rc_mux_seq_if.sv
// rc_mux_seq_if: start/done handshake, PCAM fault inputs and repair results for rc_mux_seq.
interface rc_mux_seq_if #(
  parameter int PCAM = 8,
  parameter int AW = 10,
  parameter int NSPARE = 4,
  parameter int CW = $clog2(PCAM + 1)
);
  logic start;
  logic [PCAM*AW-1:0] PCAM_addr;
  logic [PCAM-1:0] dsss;
  logic busy;
  logic done;
  logic [NSPARE*AW-1:0] repair_addr;
  logic [NSPARE-1:0] repair_vld;
  logic [CW-1:0] fault_cnt;
  logic unrepairable;
  modport master (
    output start, PCAM_addr, dsss,
    input busy, done, repair_addr, repair_vld, fault_cnt, unrepairable
  );
  modport slave (
    input start, PCAM_addr, dsss,
    output busy, done, repair_addr, repair_vld, fault_cnt, unrepairable
  );
endinterface

// File: rtl/rc_mux_seq.sv
// rc_mux_seq: sequential scan of PCAM must-repair flags, assigning the first NSPARE flagged
// addresses to spare slots and counting all flagged entries.
module rc_mux_seq #(
  parameter int PCAM = 8,
  parameter int AW = 10,
  parameter int NSPARE = 4,
  parameter int CW = $clog2(PCAM + 1)
) (
  input logic clk,
  input logic rst_n,
  rc_mux_seq_if.slave bus
);
  localparam int IW = PCAM > 1 ? $clog2(PCAM) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0] r_state;
  logic [IW-1:0] r_idx;
  logic r_last;
  logic [PCAM-1:0] r_dsss;
  logic [PCAM*AW-1:0] r_addr;
  logic [NSPARE*AW-1:0] r_acc_addr;
  logic [NSPARE-1:0] r_acc_vld;
  logic [CW-1:0] r_cnt;
  logic [NSPARE*AW-1:0] r_repair_addr;
  logic [NSPARE-1:0] r_repair_vld;
  logic [CW-1:0] r_fault_cnt;
  logic r_unrep;
  // Shadow flags/addresses shift so the entry under scan is always at the MSB flag / low address word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_last <= 1'b0;
      r_dsss <= '0;
      r_addr <= '0;
      r_acc_addr <= '0;
      r_acc_vld <= '0;
      r_cnt <= '0;
      r_repair_addr <= '0;
      r_repair_vld <= '0;
      r_fault_cnt <= '0;
      r_unrep <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (bus.start) begin
        r_dsss <= bus.dsss;
        r_addr <= bus.PCAM_addr;
        r_acc_addr <= '0;
        r_acc_vld <= '0;
        r_cnt <= '0;
        r_idx <= '0;
        r_last <= 1'b0;
        r_state <= S_SCAN;
      end
    end else if (r_state == S_SCAN) begin
      if (r_last) begin
        r_repair_addr <= r_acc_addr;
        r_repair_vld <= r_acc_vld;
        r_fault_cnt <= r_cnt;
        r_unrep <= int'(r_cnt) > NSPARE;
        r_state <= S_DONE;
      end else begin
        if (r_dsss[PCAM-1]) begin
          if (int'(r_cnt) < PCAM) r_cnt <= r_cnt + 1'b1;
          for (int s = 0; s < NSPARE; s++)
            if (int'(r_cnt) == s) begin
              r_acc_addr[s*AW +: AW] <= r_addr[AW-1:0];
              r_acc_vld[s] <= 1'b1;
            end
        end
        r_dsss <= r_dsss << 1;
        r_addr <= r_addr >> AW;
        r_idx <= r_idx + 1'b1;
        r_last <= r_idx == IW'(PCAM - 1);
      end
    end else begin
      r_state <= S_IDLE;
    end
  end
  assign bus.busy = r_state != S_IDLE;
  assign bus.done = r_state == S_DONE;
  assign bus.repair_addr = r_repair_addr;
  assign bus.repair_vld = r_repair_vld;
  assign bus.fault_cnt = r_fault_cnt;
  assign bus.unrepairable = r_unrep;
endmodule

// File: tb/tb_rc_mux_seq.sv
// tb_rc_mux_seq: scoreboard bench for rc_mux_seq in the default and a 16-entry/6-spare configuration.
module tb_rc_mux_seq;
  typedef struct packed {
    logic [71:0] addr;
    logic [5:0] vld;
    logic [4:0] cnt;
    logic unrep;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [79:0] addr_a;
  logic [191:0] addr_b;
  rc_mux_seq_if #(.PCAM(8), .AW(10), .NSPARE(4)) ia();
  rc_mux_seq_if #(.PCAM(16), .AW(12), .NSPARE(6)) ib();
  rc_mux_seq #(.PCAM(8), .AW(10), .NSPARE(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  rc_mux_seq #(.PCAM(16), .AW(12), .NSPARE(6)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  always #5 clk = ~clk;
  function automatic exp_t model(input int p, input int ns, input int aw, input logic [15:0] d,
                                 input logic [191:0] a);
    exp_t e;
    int c;
    e = '0;
    c = 0;
    for (int i = 0; i < p; i++)
      if (d[p-1-i]) begin
        if (c < ns) begin
          for (int b = 0; b < aw; b++) e.addr[c*aw+b] = a[i*aw+b];
          e.vld[c] = 1'b1;
        end
        c++;
      end
    e.cnt = 5'(c);
    e.unrep = c > ns;
    return e;
  endfunction
  task automatic start_a(input logic [7:0] d);
    @(negedge clk);
    ia.dsss = d;
    ia.start = 1'b1;
    q_a.push_back(model(8, 4, 10, {8'h00, d}, {112'h0, addr_a}));
    @(negedge clk);
    ia.start = 1'b0;
  endtask
  task automatic wait_a(output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (!ia.done && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (!ia.busy) busy_ok = 1'b0;
    end
  endtask
  task automatic run_a(input string name, input logic [7:0] d);
    int n;
    bit bok;
    exp_t e;
    start_a(d);
    wait_a(n, bok);
    e = q_a.pop_front();
    vectors++;
    if (n !== 9) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, want 9", name, n);
    end
    vectors++;
    if (!bok) begin
      errors++;
      $display("FAIL %s busy: dropped before done, want high through scan", name);
    end
    vectors++;
    if ({ia.repair_addr, ia.repair_vld, ia.fault_cnt, ia.unrepairable} !==
        {e.addr[39:0], e.vld[3:0], e.cnt[3:0], e.unrep}) begin
      errors++;
      $display("FAIL %s result: got addr=%h vld=%b cnt=%0d unrep=%b, want addr=%h vld=%b cnt=%0d unrep=%b",
               name, ia.repair_addr, ia.repair_vld, ia.fault_cnt, ia.unrepairable,
               e.addr[39:0], e.vld[3:0], e.cnt[3:0], e.unrep);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({ia.done, ia.busy} !== 2'b00) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b, want 0 0", name, ia.done, ia.busy);
    end
  endtask
  task automatic test_reset;
    @(negedge clk);
    vectors++;
    if ({ia.busy, ia.done, ia.repair_addr, ia.repair_vld, ia.fault_cnt, ia.unrepairable} !== '0) begin
      errors++;
      $display("FAIL reset_a: got busy=%b done=%b addr=%h vld=%b cnt=%0d, want all 0",
               ia.busy, ia.done, ia.repair_addr, ia.repair_vld, ia.fault_cnt);
    end
    vectors++;
    if ({ib.busy, ib.done, ib.repair_addr, ib.repair_vld, ib.fault_cnt, ib.unrepairable} !== '0) begin
      errors++;
      $display("FAIL reset_b: got busy=%b done=%b addr=%h vld=%b cnt=%0d, want all 0",
               ib.busy, ib.done, ib.repair_addr, ib.repair_vld, ib.fault_cnt);
    end
  endtask
  task automatic test_basic;
    run_a("basic_a1", 8'b1010_0001);
    vectors++;
    if ({ia.repair_addr, ia.repair_vld} !== {10'h000, 10'h107, 10'h102, 10'h100, 4'b0111}) begin
      errors++;
      $display("FAIL basic_slots: got %h vld=%b, want 000/107/102/100 vld=0111",
               ia.repair_addr, ia.repair_vld);
    end
  endtask
  task automatic test_all_flags;
    run_a("all_ff", 8'hFF);
    vectors++;
    if ({ia.fault_cnt, ia.unrepairable} !== {4'd8, 1'b1}) begin
      errors++;
      $display("FAIL all_cnt: got cnt=%0d unrep=%b, want 8 1", ia.fault_cnt, ia.unrepairable);
    end
  endtask
  task automatic test_no_flags;
    run_a("none_00", 8'h00);
    run_a("exact_0f", 8'h0F);
    run_a("mixed_5a", 8'h5A);
  endtask
  task automatic test_start_while_busy;
    int n;
    int extra;
    bit bok;
    exp_t e;
    start_a(8'h80);
    repeat (3) @(negedge clk);
    ia.dsss = 8'hFF;
    ia.PCAM_addr = ~addr_a;
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    wait_a(n, bok);
    e = q_a.pop_front();
    vectors++;
    if ({ia.repair_addr, ia.repair_vld, ia.fault_cnt, ia.unrepairable} !==
        {e.addr[39:0], e.vld[3:0], e.cnt[3:0], e.unrep}) begin
      errors++;
      $display("FAIL busy_start result: got addr=%h vld=%b cnt=%0d, want addr=%h vld=%b cnt=%0d",
               ia.repair_addr, ia.repair_vld, ia.fault_cnt, e.addr[39:0], e.vld[3:0], e.cnt[3:0]);
    end
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (ia.done) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_start extra_done: got %0d extra pulses, want 0", extra);
    end
    ia.PCAM_addr = addr_a;
  endtask
  task automatic test_reset_mid_scan;
    int dones;
    start_a(8'b1010_0001);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(q_a.pop_back());
    vectors++;
    if ({ia.busy, ia.done, ia.repair_addr, ia.repair_vld, ia.fault_cnt, ia.unrepairable} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b addr=%h vld=%b cnt=%0d, want all 0",
               ia.busy, ia.done, ia.repair_addr, ia.repair_vld, ia.fault_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (ia.done) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_mid no_done: got %0d pulses, want 0", dones);
    end
    run_a("after_reset", 8'b1010_0001);
  endtask
  task automatic test_back_to_back;
    run_a("b2b_first", 8'hC3);
    run_a("b2b_second", 8'h3C);
  endtask
  task automatic test_wide;
    int n;
    exp_t e;
    @(negedge clk);
    ib.dsss = 16'h8421;
    ib.start = 1'b1;
    q_b.push_back(model(16, 6, 12, 16'h8421, addr_b));
    @(negedge clk);
    ib.start = 1'b0;
    n = 0;
    while (!ib.done && n < 60) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    e = q_b.pop_front();
    vectors++;
    if (n !== 17) begin
      errors++;
      $display("FAIL wide latency: got %0d edges, want 17", n);
    end
    vectors++;
    if ({ib.repair_addr, ib.repair_vld, ib.fault_cnt, ib.unrepairable} !==
        {e.addr, e.vld, e.cnt, e.unrep}) begin
      errors++;
      $display("FAIL wide result: got addr=%h vld=%b cnt=%0d unrep=%b, want addr=%h vld=%b cnt=%0d unrep=%b",
               ib.repair_addr, ib.repair_vld, ib.fault_cnt, ib.unrepairable, e.addr, e.vld, e.cnt, e.unrep);
    end
    vectors++;
    if ({ib.repair_vld, ib.fault_cnt} !== {6'b001111, 5'd4}) begin
      errors++;
      $display("FAIL wide vld_cnt: got vld=%b cnt=%0d, want 001111 4", ib.repair_vld, ib.fault_cnt);
    end
  endtask
  initial begin
    for (int i = 0; i < 8; i++) addr_a[i*10 +: 10] = 10'h100 + 10'(i);
    for (int i = 0; i < 16; i++) addr_b[i*12 +: 12] = 12'h200 + 12'(i);
    ia.start = 1'b0;
    ia.dsss = '0;
    ia.PCAM_addr = addr_a;
    ib.start = 1'b0;
    ib.dsss = '0;
    ib.PCAM_addr = addr_b;
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_basic;
    test_all_flags;
    test_no_flags;
    test_start_while_busy;
    test_reset_mid_scan;
    test_back_to_back;
    test_wide;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
